// File: rtl/popcount_seq_if.sv
// Handshake and result bundle for the popcount_seq engine.
// The engine is the slave; the producer/consumer side is the master.
interface popcount_seq_if #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 16
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             acc_en;
    logic [CW-1:0]    thresh;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_ge;
    logic             clr_acc;
    logic [ACC_W-1:0] acc;
    logic             acc_sat;

    modport slave (
        input  in_valid, in_data, acc_en, thresh, out_ready, clr_acc,
        output in_ready, out_valid, out_count, out_ge, acc, acc_sat
    );

    modport master (
        output in_valid, in_data, acc_en, thresh, out_ready, clr_acc,
        input  in_ready, out_valid, out_count, out_ge, acc, acc_sat
    );
endinterface

// File: rtl/popcount_seq.sv
// Multi-cycle ones counter: scans WIDTH bits CHUNK per cycle, presents the count
// under a valid/ready handshake and optionally adds it into a saturating accumulator.
module popcount_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    popcount_seq_if.slave     bus
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SUM_W = ((ACC_W > CW) ? ACC_W : CW) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic              acc_en_q, acc_en_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              acc_sat_q, acc_sat_d;

    logic [CW-1:0]     chunk_ones;
    logic [SUM_W-1:0]  acc_sum;

    // The word is shifted down each BUSY cycle, so the live chunk is always the low CHUNK bits.
    always_comb begin
        chunk_ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_ones = chunk_ones + CW'(data_q[i]);
        end
    end

    assign acc_sum = SUM_W'(acc_q) + SUM_W'(count_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        data_d    = data_q;
        idx_d     = idx_q;
        count_d   = count_q;
        acc_en_d  = acc_en_q;
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d   = bus.in_data;
                    acc_en_d = bus.acc_en;
                    count_d  = '0;
                    idx_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                count_d = count_q + chunk_ones;
                data_d  = data_q >> CHUNK;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    if (acc_en_q) begin
                        if (acc_sum > SUM_W'(ACC_MAX)) begin
                            acc_d     = ACC_MAX;
                            acc_sat_d = 1'b1;
                        end else begin
                            acc_d = acc_sum[ACC_W-1:0];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a coincident accumulate.
        if (bus.clr_acc) begin
            acc_d     = '0;
            acc_sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            acc_en_q  <= 1'b0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            acc_en_q  <= acc_en_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_count = count_q;
    assign bus.out_ge    = (count_q >= bus.thresh);
    assign bus.acc       = acc_q;
    assign bus.acc_sat   = acc_sat_q;
endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq: stimulus pushes expected counts into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_popcount_seq;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int ACC_W = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    popcount_seq_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus_if ();

    popcount_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input logic en, input bit push, input int exp);
        int n = 0;
        while (!bus_if.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_in_ready", int'(bus_if.in_ready), 1);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = w;
        bus_if.acc_en   = en;
        if (push) exp_q.push_back(exp);
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.acc_en   = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus_if.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("wait_out_valid", int'(bus_if.out_valid), 1);
    endtask

    task automatic take();
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
    endtask

    task automatic run_word(input logic [WIDTH-1:0] w, input logic en, input int exp);
        send(w, en, 1'b1, exp);
        wait_out();
        take();
        check("in_ready_after_take", int'(bus_if.in_ready), 1);
    endtask

    // Scoreboard monitor: one comparison per output handshake.
    always @(negedge clk) begin
        if (!reset && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got count %0d expected no result", bus_if.out_count);
            end else begin
                check("sb_out_count", int'(bus_if.out_count), exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_t[3];

        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.acc_en    = 1'b0;
        bus_if.thresh    = '0;
        bus_if.out_ready = 1'b0;
        bus_if.clr_acc   = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready",  int'(bus_if.in_ready),  1);
        check("rst_out_valid", int'(bus_if.out_valid), 0);
        check("rst_out_count", int'(bus_if.out_count), 0);
        check("rst_acc",       int'(bus_if.acc),       0);
        check("rst_acc_sat",   int'(bus_if.acc_sat),   0);

        // All ones: out_valid first high after accept edge + 4
        send(32'hFFFF_FFFF, 1'b0, 1'b1, 32);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("lat_not_yet_valid", int'(bus_if.out_valid), 0);
        end
        tick();
        check("lat_valid_at_T4", int'(bus_if.out_valid), 1);
        check("lat_count",       int'(bus_if.out_count), 32);
        take();
        check("lat_in_ready_back", int'(bus_if.in_ready), 1);

        // End bits and chunk boundaries
        run_word(32'h0000_0000, 1'b0, 0);
        run_word(32'h8000_0001, 1'b0, 2);
        run_word(32'h0F0F_00F0, 1'b0, 12);

        // Back-pressure in DONE: result held, input pulses ignored
        send(32'h00FF_00FF, 1'b0, 1'b1, 16);
        wait_out();
        for (int i = 0; i < 3; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = 32'hFFFF_FFFF;
            tick();
            check("hold_out_valid", int'(bus_if.out_valid), 1);
            check("hold_out_count", int'(bus_if.out_count), 16);
            check("hold_in_ready",  int'(bus_if.in_ready),  0);
        end
        bus_if.in_valid = 1'b0;
        take();
        check("release_in_ready",  int'(bus_if.in_ready),  1);
        check("release_out_valid", int'(bus_if.out_valid), 0);

        // Accumulator saturation and clear
        check("acc_before", int'(bus_if.acc), 0);
        run_word(32'hFFFF_FFFF, 1'b1, 32);
        check("acc_first",     int'(bus_if.acc),     32);
        check("acc_sat_first", int'(bus_if.acc_sat), 0);
        run_word(32'hFFFF_FFFF, 1'b1, 32);
        check("acc_saturated", int'(bus_if.acc),     63);
        check("acc_sat_set",   int'(bus_if.acc_sat), 1);
        bus_if.clr_acc = 1'b1;
        tick();
        bus_if.clr_acc = 1'b0;
        check("clr_acc",     int'(bus_if.acc),     0);
        check("clr_acc_sat", int'(bus_if.acc_sat), 0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1, 32);
        wait_out();
        bus_if.out_ready = 1'b1;
        bus_if.clr_acc   = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        bus_if.clr_acc   = 1'b0;
        check("clr_on_handshake", int'(bus_if.acc),     0);
        check("clr_on_hs_sat",    int'(bus_if.acc_sat), 0);

        // Reset in the middle of BUSY discards the word
        run_word(32'h0000_00FF, 1'b1, 8);
        check("acc_pre_reset", int'(bus_if.acc), 8);
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_ready",  int'(bus_if.in_ready),  1);
        check("midrst_out_valid", int'(bus_if.out_valid), 0);
        check("midrst_acc",       int'(bus_if.acc),       0);
        check("midrst_out_count", int'(bus_if.out_count), 0);
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("midrst_no_result", int'(bus_if.out_valid), 0);
        bus_if.out_ready = 1'b0;

        // Threshold compare on live thresh
        bus_if.thresh = 6'd16;
        send(32'h0000_FFFF, 1'b0, 1'b1, 16);
        wait_out();
        check("ge_thresh16", int'(bus_if.out_ge), 1);
        bus_if.thresh = 6'd17;
        #1;
        check("ge_thresh17", int'(bus_if.out_ge), 0);
        take();

        // Back-to-back throughput with out_ready held high
        bus_if.out_ready = 1'b1;
        send(32'h0000_FFFF, 1'b0, 1'b1, 16);
        acc_t[0] = cyc;
        send(32'h1234_5678, 1'b0, 1'b1, 13);
        acc_t[1] = cyc;
        send(32'hFFFF_FFFF, 1'b0, 1'b1, 32);
        acc_t[2] = cyc;
        check("b2b_gap_0_1", acc_t[1] - acc_t[0], 6);
        check("b2b_gap_1_2", acc_t[2] - acc_t[1], 6);
        for (int i = 0; i < 10; i++) tick();
        bus_if.out_ready = 1'b0;

        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
